// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: switch input, LED register, debounced confirm button
// with a sticky event flag, and a multiplexed seven-segment scanner.
module mmio_io_hub #(
    parameter int          SW_WIDTH  = 16,
    parameter int          LED_WIDTH = 16,
    parameter int          DIGITS    = 8,
    parameter int          DB_CYCLES = 1000000,
    parameter int          SCAN_DIV  = 50000,
    parameter logic [21:0] IO_BASE   = 22'h3FFFFF
) (
    input  logic                 clock,
    input  logic                 rst,
    input  logic [31:0]          addr,
    input  logic                 wen,
    input  logic                 ren,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata,
    input  logic [SW_WIDTH-1:0]  switches,
    input  logic                 confirm_button,
    output logic [LED_WIDTH-1:0] ledout,
    output logic [DIGITS-1:0]    seg_en,
    output logic [7:0]           seg_out
);
    localparam int DB_W  = $clog2(DB_CYCLES);
    localparam int DIV_W = $clog2(SCAN_DIV);

    localparam logic [7:0] OFF_LED     = 8'h18;
    localparam logic [7:0] OFF_SW      = 8'h1C;
    localparam logic [7:0] OFF_BTN     = 8'h1D;
    localparam logic [7:0] OFF_SEGDATA = 8'h20;
    localparam logic [7:0] OFF_SEGMASK = 8'h21;

    // Bus: wen/ren are single-cycle strobes qualified by sel; writes commit on
    // the rising edge, reads are combinational with no wait states.
    logic       sel;
    logic [7:0] word;
    logic       wr;
    logic       btn_rd;

    logic [LED_WIDTH-1:0] led_q;
    logic [31:0]          led_ext;
    logic [31:0]          led_wr;
    logic [SW_WIDTH-1:0]  sw_s1, sw_s2;
    logic                 btn_s1, btn_s2;
    logic                 db_level;
    logic [DB_W-1:0]      db_cnt;
    logic                 db_done;
    logic                 db_rise;
    logic                 pending;
    logic [31:0]          seg_data;
    logic [DIGITS-1:0]    seg_mask;
    logic [DIV_W-1:0]     div_cnt;
    logic [2:0]           digit_idx;
    logic [7:0]           mask_ext;
    logic [7:0]           en_full;
    logic [3:0]           nibble;
    logic                 unused_bits;

    assign sel    = (addr[31:10] == IO_BASE);
    assign word   = addr[9:2];
    assign wr     = sel & wen;
    assign btn_rd = sel & ren & (word == OFF_BTN);
    assign ledout = led_q;

    // addr[1] picks which LED halfword a write replaces.
    always_comb begin
        led_ext = 32'(led_q);
        led_wr  = addr[1] ? {wdata[15:0], led_ext[15:0]} : {led_ext[31:16], wdata[15:0]};
    end

    assign db_done = (db_cnt == DB_W'(DB_CYCLES - 1));
    assign db_rise = btn_s2 & ~db_level & db_done;

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            led_q    <= '0;
            seg_data <= '0;
            seg_mask <= '0;
        end else if (wr) begin
            case (word)
                OFF_LED:     led_q    <= led_wr[LED_WIDTH-1:0];
                OFF_SEGDATA: seg_data <= wdata;
                OFF_SEGMASK: seg_mask <= wdata[DIGITS-1:0];
                default:     ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            sw_s1  <= '0;
            sw_s2  <= '0;
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
        end else begin
            sw_s1  <= switches;
            sw_s2  <= sw_s1;
            btn_s1 <= confirm_button;
            btn_s2 <= btn_s1;
        end
    end

    // Level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            db_level <= 1'b0;
            db_cnt   <= '0;
            pending  <= 1'b0;
        end else begin
            if (btn_s2 == db_level) begin
                db_cnt <= '0;
            end else if (db_done) begin
                db_level <= btn_s2;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
            if (db_rise)
                pending <= 1'b1;
            else if (btn_rd)
                pending <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            div_cnt   <= '0;
            digit_idx <= '0;
        end else if (div_cnt == DIV_W'(SCAN_DIV - 1)) begin
            div_cnt   <= '0;
            digit_idx <= (digit_idx == 3'(DIGITS - 1)) ? 3'd0 : digit_idx + 3'd1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    always_comb begin
        mask_ext = 8'(seg_mask);
        nibble   = seg_data[{digit_idx, 2'b00} +: 4];
        en_full  = 8'hFF;
        seg_out  = 8'hFF;
        if (mask_ext[digit_idx]) begin
            en_full = ~(8'd1 << digit_idx);
            case (nibble)
                4'h0: seg_out = 8'hC0;
                4'h1: seg_out = 8'hF9;
                4'h2: seg_out = 8'hA4;
                4'h3: seg_out = 8'hB0;
                4'h4: seg_out = 8'h99;
                4'h5: seg_out = 8'h92;
                4'h6: seg_out = 8'h82;
                4'h7: seg_out = 8'hF8;
                4'h8: seg_out = 8'h80;
                4'h9: seg_out = 8'h90;
                4'hA: seg_out = 8'h88;
                4'hB: seg_out = 8'h83;
                4'hC: seg_out = 8'hC6;
                4'hD: seg_out = 8'hA1;
                4'hE: seg_out = 8'h86;
                default: seg_out = 8'h8E;
            endcase
        end
    end

    assign seg_en = en_full[DIGITS-1:0];

    always_comb begin
        rdata = 32'd0;
        if (sel && ren) begin
            case (word)
                OFF_LED:     rdata = 32'(led_q);
                OFF_SW:      rdata = 32'(sw_s2);
                OFF_BTN:     rdata = {30'd0, db_level, pending};
                OFF_SEGDATA: rdata = seg_data;
                OFF_SEGMASK: rdata = 32'(seg_mask);
                default:     rdata = 32'd0;
            endcase
        end
    end

    assign unused_bits = ^{addr[0], led_wr, en_full};
endmodule

// File: tb/tb_mmio_io_hub.sv
// Self-checking bench for mmio_io_hub: directed steps plus randomized bus and
// pin traffic, checked against a cycle-count based reference model.
module tb_mmio_io_hub;
    localparam int DB       = 8;
    localparam int SCAN_DIV = 4;
    localparam int DIGITS   = 8;

    localparam logic [31:0] A_LED  = 32'hFFFFFC60;
    localparam logic [31:0] A_SW   = 32'hFFFFFC70;
    localparam logic [31:0] A_BTN  = 32'hFFFFFC74;
    localparam logic [31:0] A_SEGD = 32'hFFFFFC80;
    localparam logic [31:0] A_SEGM = 32'hFFFFFC84;

    logic        clock;
    logic        rst;
    logic [31:0] addr;
    logic        wen;
    logic        ren;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] switches;
    logic        confirm_button;
    logic [15:0] ledout;
    logic [7:0]  seg_en;
    logic [7:0]  seg_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [15:0] m_led;
    logic [31:0] m_segdata;
    logic [7:0]  m_segmask;
    logic        m_pend;
    logic        m_level;
    int          m_run;
    int          m_cyc;
    logic [15:0] sw_q[$];
    logic        btn_q[$];

    logic [7:0]  hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                  8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic [31:0] addr_tab [8] = '{32'hFFFFFC60, 32'hFFFFFC62, 32'hFFFFFC70, 32'hFFFFFC74,
                                  32'hFFFFFC80, 32'hFFFFFC84, 32'hFFFFFC88, 32'h00000C60};
    logic [7:0]  en_tab  [8]  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    logic [7:0]  out_tab [8]  = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    mmio_io_hub #(
        .SW_WIDTH(16), .LED_WIDTH(16), .DIGITS(DIGITS),
        .DB_CYCLES(DB), .SCAN_DIV(SCAN_DIV), .IO_BASE(22'h3FFFFF)
    ) dut (
        .clock(clock), .rst(rst), .addr(addr), .wen(wen), .ren(ren),
        .wdata(wdata), .rdata(rdata), .switches(switches),
        .confirm_button(confirm_button), .ledout(ledout),
        .seg_en(seg_en), .seg_out(seg_out)
    );

    // Clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic m_sel();
        return addr[31:10] == 22'h3FFFFF;
    endfunction

    function automatic logic [31:0] m_rdata();
        if (!(m_sel() && ren)) return 32'd0;
        case (addr[9:0] & 10'h3FC)
            10'h060: return 32'(m_led);
            10'h070: return 32'(sw_q[0]);
            10'h074: return {30'd0, m_level, m_pend};
            10'h080: return m_segdata;
            10'h084: return 32'(m_segmask);
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic m_rise_next();
        return btn_q[0] && !m_level && (m_run == DB - 1);
    endfunction

    task automatic model_reset();
        m_led = '0; m_segdata = '0; m_segmask = '0;
        m_pend = 1'b0; m_level = 1'b0; m_run = 0; m_cyc = 0;
        sw_q = '{16'd0, 16'd0};
        btn_q = '{1'b0, 1'b0};
    endtask

    // Advance the model by one rising edge using the inputs present before it.
    task automatic model_edge();
        logic s;
        if (m_sel() && wen) begin
            case (addr[9:0] & 10'h3FC)
                10'h060: if (!addr[1]) m_led = wdata[15:0];
                10'h080: m_segdata = wdata;
                10'h084: m_segmask = wdata[7:0];
                default: ;
            endcase
        end
        if (m_sel() && ren && ((addr[9:0] & 10'h3FC) == 10'h074)) m_pend = 1'b0;
        s = btn_q[0];
        if (s != m_level) m_run++;
        else m_run = 0;
        if (m_run == DB) begin
            m_level = s;
            m_run = 0;
            if (m_level) m_pend = 1'b1;
        end
        btn_q.push_back(confirm_button);
        void'(btn_q.pop_front());
        sw_q.push_back(switches);
        void'(sw_q.pop_front());
        m_cyc++;
    endtask

    task automatic check_outputs();
        int idx;
        logic [7:0] e_en, e_out;
        idx = (m_cyc / SCAN_DIV) % DIGITS;
        if (m_segmask[idx]) begin
            e_en  = ~(8'd1 << idx);
            e_out = hex_tab[m_segdata[idx*4 +: 4]];
        end else begin
            e_en  = 8'hFF;
            e_out = 8'hFF;
        end
        check("ledout", 32'(ledout), 32'(m_led));
        check("seg_en", 32'(seg_en), 32'(e_en));
        check("seg_out", 32'(seg_out), 32'(e_out));
        check("rdata", rdata, m_rdata());
    endtask

    // Driver tasks
    task automatic tick();
        model_edge();
        @(posedge clock);
        #1;
        check_outputs();
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        addr = a; wdata = d; wen = 1'b1;
        tick();
        wen = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        addr = a; ren = 1'b1;
        #1;
        d = rdata;
        check("rd_model", rdata, m_rdata());
        tick();
        ren = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic        found;
        int          op;
        logic [31:0] a;

        rst = 1'b1; addr = '0; wen = 1'b0; ren = 1'b0; wdata = '0;
        switches = '0; confirm_button = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("rst_ledout", 32'(ledout), 32'h0);
        check("rst_seg_en", 32'(seg_en), 32'hFF);
        check("rst_seg_out", 32'(seg_out), 32'hFF);
        rst = 1'b0;
        check_outputs();

        // LED register
        do_write(A_LED, 32'h0000BEEF);
        check("led_write", 32'(ledout), 32'h0000BEEF);
        do_read(A_LED, d);
        check("led_read", d, 32'h0000BEEF);
        do_write(A_SW, 32'h12345678);
        check("ro_write_ignored", 32'(ledout), 32'h0000BEEF);
        do_write(32'hFFFFFC62, 32'h0000AAAA);
        check("led_upper_absent", 32'(ledout), 32'h0000BEEF);

        // Switch synchroniser latency
        switches = 16'h1234; addr = A_SW; ren = 1'b1;
        #1;
        check("sw_pre", rdata, 32'h0);
        tick();
        check("sw_edge1", rdata, 32'h0);
        tick();
        check("sw_edge2", rdata, 32'h00001234);
        addr = 32'h00000070;
        #1;
        check("nosel_read", rdata, 32'h0);
        ren = 1'b0;

        // Short bounce produces no event
        confirm_button = 1'b1;
        repeat (5) tick();
        confirm_button = 1'b0;
        repeat (15) tick();
        do_read(A_BTN, d);
        check("btn_bounce", d, 32'h0);

        // Long press: pending + level, then read clears pending
        confirm_button = 1'b1;
        repeat (20) tick();
        do_read(A_BTN, d);
        check("btn_press", d, 32'h3);
        do_read(A_BTN, d);
        check("btn_cleared", d, 32'h2);
        confirm_button = 1'b0;
        repeat (15) tick();
        do_read(A_BTN, d);
        check("btn_release", d, 32'h0);

        // Read on the very edge the level rises: set wins over clear
        confirm_button = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
            if (m_rise_next()) found = 1'b1;
            else tick();
        end
        check("rise_found", 32'(found), 32'h1);
        do_read(A_BTN, d);
        check("btn_same_edge", d, 32'h0);
        do_read(A_BTN, d);
        check("btn_after_same_edge", d, 32'h3);
        confirm_button = 1'b0;
        repeat (15) tick();

        // Scanner sequence
        do_write(A_SEGD, 32'h76543210);
        do_write(A_SEGM, 32'h0000000F);
        for (int k = 0; k < 40 && (m_cyc % (SCAN_DIV * DIGITS)) != 0; k++) tick();
        check("scan_align", 32'(m_cyc % (SCAN_DIV * DIGITS)), 32'h0);
        for (int slot = 0; slot < 9; slot++) begin
            for (int k = 0; k < SCAN_DIV; k++) begin
                check("scan_en", 32'(seg_en), 32'(en_tab[slot % 8]));
                check("scan_out", 32'(seg_out), 32'(out_tab[slot % 8]));
                tick();
            end
        end

        // Asynchronous reset mid-scan
        do_write(A_LED, 32'h0000A5A5);
        repeat (5) tick();
        #2;
        rst = 1'b1;
        #1;
        check("arst_ledout", 32'(ledout), 32'h0);
        check("arst_seg_en", 32'(seg_en), 32'hFF);
        check("arst_seg_out", 32'(seg_out), 32'hFF);
        @(posedge clock);
        #1;
        rst = 1'b0;
        model_reset();
        check_outputs();
        do_write(A_SEGM, 32'h00000001);
        check("scan_restart", 32'(seg_en), 32'hFE);
        do_read(A_SEGD, d);
        check("segdata_reset", d, 32'h0);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            op = $urandom_range(0, 7);
            a  = addr_tab[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) confirm_button = ~confirm_button;
            case (op)
                0, 1, 2: do_write(a, $urandom());
                3, 4, 5: do_read(a, d);
                6: begin
                    switches = 16'($urandom());
                    tick();
                end
                default: tick();
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_io_hub.md
Name: mmio_io_hub

Overview:
- Parametrised memory-mapped I/O unit for the minisys CPU, sitting between MemOrIO-style address decode and the board pins.
- Replaces the separate single-purpose switch-read and LED-write blocks with one unit:
  - synchronised switch input;
  - LED register with halfword write enables;
  - debounced confirm button with a sticky event flag;
  - N-digit multiplexed seven-segment scanner.
- CPU reads and writes through one word-addressed register window.

Parameters:
- SW_WIDTH, 16, switch input width (1..32).
- LED_WIDTH, 16, LED output width (1..32).
- DIGITS, 8, seven-segment digit count (1..8).
- DB_CYCLES, 1000000, stable cycles required to accept a button level change (≥2; bench overrides to 8).
- SCAN_DIV, 50000, clock cycles per digit slot (≥2; bench overrides to 4).
- IO_BASE, 22'h3FFFFF, value of addr[31:10] that selects this block.

Ports:
- clock, input, 1, system clock; all state on rising edge.
- rst, input, 1, asynchronous active-high reset.
- addr, input, 32, byte address from ALU result.
- wen, input, 1, I/O write strobe (IOWrite).
- ren, input, 1, I/O read strobe (IORead).
- wdata, input, 32, write data (register read data 2).
- rdata, output, 32, read data to MemOrIO.
- switches, input, SW_WIDTH, raw board switches.
- confirm_button, input, 1, raw push button, active-high.
- ledout, output, LED_WIDTH, LED drive.
- seg_en, output, DIGITS, digit enables, active-low.
- seg_out, output, 8, segments {dp,g,f,e,d,c,b,a}, active-low.

Behaviour:
- Select condition: sel = (addr[31:10] == IO_BASE). Offset = addr[9:0]; addr[1:0] ignored.
- Register map:
  - 0x060 LED: RW.
  - 0x070 SW: RO.
  - 0x074 BTN: RO; bit0 = pending, bit1 = debounced level.
  - 0x080 SEGDATA: RW; 4 bits per digit, digit i = bits [4i+3:4i].
  - 0x084 SEGMASK: RW; bit i enables digit i.
- Writes:
  - Take effect on the clock edge when sel & wen.
  - LED writes: addr[1] = 0 writes ledout[15:0]; addr[1] = 1 writes bits [LED_WIDTH-1:16], if present, from wdata[15:0].
  - Writes to RO or unmapped offsets are ignored.
- Reads:
  - rdata is combinational, zero-extended.
  - rdata is 0 when !(sel & ren) or when the offset is unmapped.
- Switch path:
  - 2-flop synchroniser; SW returns the second-stage value.
  - Latency: 2 clocks from a pin change to a visible read.
- Button path:
  - 2-flop synchroniser feeds a debounce counter.
  - Counter clears whenever the sync value equals the debounced level.
  - When the counter reaches DB_CYCLES-1 with the sync value still different, the debounced level flips and the counter clears.
  - A 0→1 flip of the debounced level sets pending.
- Pending clear and priority:
  - A read of BTN (sel & ren & offset 0x074) clears pending on that clock edge.
  - The read returns the pre-clear value.
  - If a set and a read-clear occur on the same edge, set wins: pending = 1.
  - Bounces shorter than DB_CYCLES produce no event.
- Scanner:
  - A divider counts 0..SCAN_DIV-1. On wrap, digit index advances 0..DIGITS-1 and wraps to 0.
  - seg_en: only the bit for the current index is low, and only if that digit's SEGMASK bit is 1; otherwise all bits are high.
  - seg_out: hex decode of the current nibble, active-low, dp = 1. Decode table: 0 = 8'hC0, 1 = 8'hF9, … F = 8'h8E. A disabled slot drives 8'hFF.
  - Writes to SEGDATA/SEGMASK take effect from the next cycle's output without resetting the scan.
- Reset, asynchronous, at any time:
  - ledout = 0; SEGDATA = 0; SEGMASK = 0.
  - Synchronisers = 0; debounced level = 0; pending = 0; debounce counter = 0.
  - Divider = 0; index = 0.
  - seg_en = all 1; seg_out = 8'hFF.
  - rdata follows its combinational rule.
- Button held through reset deassertion: the debounce runs normally, and pending sets DB_CYCLES+2 clocks after rst falls.

Test Plan:
- rst pulse mid-scan with ledout = 16'hA5A5 → all outputs return to reset values immediately (asynchronous); scan restarts at digit 0 after rst falls.
- Write 0xFFFFFC60 ← 32'h0000BEEF with wen → ledout = 16'hBEEF next edge. Read 0xFFFFFC60 → rdata = 32'h0000BEEF. Write 0xFFFFFC70 → no effect.
- switches = 16'h1234 → read SW returns 0 before the 2nd clock edge, then 32'h00001234. addr[31:10] ≠ IO_BASE with ren → rdata = 0.
- DB_CYCLES = 8: button high for 5 clocks, then low → no pending. Button high for 20 clocks → BTN reads 32'h3. Next read returns 32'h2.
- Read BTN on the same edge the debounced level rises → that read returns bit0 = 0; the following read returns bit0 = 1.
- SCAN_DIV = 4, DIGITS = 8, SEGDATA = 32'h76543210, SEGMASK = 8'h0F:
  - seg_en steps FE, FD, FB, F7 every 4 clocks, with seg_out C0, F9, A4, B0.
  - Then 4 slots of seg_en = FF, seg_out = FF.
  - Then the sequence wraps back to FE.
